// File: rtl/esc_pwm_array.sv
// Frame-synchronous multi-channel ESC pulse generator with speed clamp,
// arm gate and a write watchdog that idles every channel when writes stop.
module esc_pwm_array #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned SPEED_W        = 11,
    parameter int unsigned SCALE          = 3,
    parameter int unsigned MIN_PULSE      = 6250,
    parameter int unsigned MAX_SPEED      = 2047,
    parameter int unsigned PERIOD         = 125000,
    parameter int unsigned TIMEOUT_FRAMES = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wrt,
    input  logic [NUM_CH*SPEED_W-1:0] speed,
    input  logic                      arm,
    output logic [NUM_CH-1:0]         PWM,
    output logic                      frame_start,
    output logic                      timeout
);
    localparam int unsigned CW        = $clog2(PERIOD);
    localparam int unsigned WDW       = $clog2(TIMEOUT_FRAMES + 1);
    localparam int unsigned FIELD_MAX = (2 ** SPEED_W) - 1;
    localparam int unsigned CEIL      = (MAX_SPEED < FIELD_MAX) ? MAX_SPEED : FIELD_MAX;
    localparam logic [SPEED_W-1:0] MAX_S = SPEED_W'(CEIL);

    logic [CW-1:0]      fcnt;
    logic               pend;
    logic [WDW-1:0]     wd;
    logic [SPEED_W-1:0] shadow  [NUM_CH];
    logic [CW-1:0]      pcnt    [NUM_CH];
    logic [SPEED_W-1:0] clamped [NUM_CH];
    logic [SPEED_W-1:0] eff     [NUM_CH];
    logic [CW-1:0]      width   [NUM_CH];
    logic               fs_now;
    logic               trip;

    // pend forces a frame start on the first edge after reset while the
    // frame counter still sits at its PERIOD-1 reset value.
    always_comb begin
        fs_now  = pend || (fcnt == '0);
        trip    = !wrt && (wd >= WDW'(TIMEOUT_FRAMES - 1));
        clamped = '{default: '0};
        eff     = '{default: '0};
        width   = '{default: '0};
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            clamped[i] = (speed[i*SPEED_W +: SPEED_W] > MAX_S) ? MAX_S
                                                                : speed[i*SPEED_W +: SPEED_W];
            eff[i]     = wrt ? clamped[i] : shadow[i];
            if (!arm || trip) begin
                eff[i] = '0;
            end
            width[i]   = CW'(MIN_PULSE) + CW'(SCALE) * CW'(eff[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt        <= CW'(PERIOD - 1);
            pend        <= 1'b1;
            wd          <= '0;
            PWM         <= '0;
            frame_start <= 1'b0;
            timeout     <= 1'b1;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
                pcnt[i]   <= '0;
            end
        end else begin
            pend        <= 1'b0;
            frame_start <= fs_now;
            fcnt        <= fs_now ? CW'(PERIOD - 1) : fcnt - CW'(1);

            if (wrt) begin
                wd      <= '0;
                timeout <= 1'b0;
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    shadow[i] <= clamped[i];
                end
            end else if (fs_now) begin
                if (wd != WDW'(TIMEOUT_FRAMES)) begin
                    wd <= wd + WDW'(1);
                end
                if (trip) begin
                    timeout <= 1'b1;
                end
            end

            // Pulse ends on the edge where its counter steps 1 -> 0.
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (fs_now) begin
                    pcnt[i] <= width[i];
                    PWM[i]  <= 1'b1;
                end else if (pcnt[i] != '0) begin
                    pcnt[i] <= pcnt[i] - CW'(1);
                    if (pcnt[i] == CW'(1)) begin
                        PWM[i] <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_esc_pwm_array.sv
// Scoreboard bench for esc_pwm_array: expected per-frame pulse widths are
// queued by the stimulus and compared as each frame completes.
module tb_esc_pwm_array;
    localparam int unsigned NUM_CH         = 4;
    localparam int unsigned SPEED_W        = 6;
    localparam int unsigned SCALE          = 2;
    localparam int unsigned MIN_PULSE      = 10;
    localparam int unsigned MAX_SPEED      = 50;
    localparam int unsigned PERIOD         = 200;
    localparam int unsigned TIMEOUT_FRAMES = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      wrt;
    logic                      arm;
    logic [NUM_CH*SPEED_W-1:0] speed;
    logic [NUM_CH-1:0]         pwm;
    logic                      frame_start;
    logic                      timeout;

    int checks   = 0;
    int failures = 0;
    int sb[$];

    always #5 clk = ~clk;

    esc_pwm_array #(
        .NUM_CH(NUM_CH),
        .SPEED_W(SPEED_W),
        .SCALE(SCALE),
        .MIN_PULSE(MIN_PULSE),
        .MAX_SPEED(MAX_SPEED),
        .PERIOD(PERIOD),
        .TIMEOUT_FRAMES(TIMEOUT_FRAMES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wrt(wrt),
        .speed(speed),
        .arm(arm),
        .PWM(pwm),
        .frame_start(frame_start),
        .timeout(timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pw(input int s);
        return MIN_PULSE + SCALE * ((s > MAX_SPEED) ? MAX_SPEED : s);
    endfunction

    task automatic expect_frame(input int w0, input int w1, input int w2, input int w3);
        sb.push_back(w0);
        sb.push_back(w1);
        sb.push_back(w2);
        sb.push_back(w3);
    endtask

    // Frame monitor: measures each channel's high time from one frame start
    // to the next; a frame cut short by reset is discarded.
    int len;
    int w[NUM_CH];
    bit in_frame = 1'b0;

    task automatic finish_frame();
        check("period", len, PERIOD);
        if (sb.size() < NUM_CH) begin
            check("sb_empty", sb.size(), NUM_CH);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                check($sformatf("width_ch%0d", i), w[i], sb.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
        end else if (frame_start) begin
            if (in_frame) finish_frame();
            in_frame = 1'b1;
            len      = 0;
            for (int i = 0; i < NUM_CH; i++) w[i] = 0;
        end
        if (in_frame) begin
            len++;
            for (int i = 0; i < NUM_CH; i++) begin
                if (pwm[i]) w[i]++;
            end
        end
    end

    task automatic skip(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 2 * PERIOD);
        if (!frame_start) check({tag, "_fs_wait"}, 0, 1);
    endtask

    task automatic write(input int s0, input int s1, input int s2, input int s3);
        wrt   = 1'b1;
        speed = {SPEED_W'(s3), SPEED_W'(s2), SPEED_W'(s1), SPEED_W'(s0)};
        @(posedge clk);
        #1 wrt = 1'b0;
        @(negedge clk);
        check("timeout_clear", timeout, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        wrt   = 1'b0;
        arm   = 1'b1;
        speed = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pwm", pwm, 0);
        check("rst_fs", frame_start, 0);
        check("rst_timeout", timeout, 1);

        // Frame A: unfed after reset, all idle width.
        expect_frame(pw(0), pw(0), pw(0), pw(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_fs("A");
        check("first_pwm", pwm, 4'hF);
        check("unfed_timeout", timeout, 1);

        // Mid-frame write with a clamped channel appears in frame B.
        skip(49);
        write(0, 63, 20, 30);
        expect_frame(pw(0), pw(63), pw(20), pw(30));
        wait_fs("B");

        // Write while B's pulses are in flight; B is unchanged, C uses it.
        skip(29);
        expect_frame(pw(25), pw(25), pw(25), pw(25));
        write(25, 25, 25, 25);
        wait_fs("C");

        // Write on the frame-start edge of D bypasses the shadow.
        expect_frame(pw(40), pw(0), pw(10), pw(50));
        skip(PERIOD - 1);
        write(40, 0, 10, 50);
        check("same_edge_fs", frame_start, 1);

        // Disarmed frame E, rearmed for F.
        expect_frame(pw(0), pw(0), pw(0), pw(0));
        skip(149);
        arm = 1'b0;
        wait_fs("E");
        check("arm_timeout", timeout, 0);
        expect_frame(pw(40), pw(0), pw(10), pw(50));
        skip(99);
        arm = 1'b1;
        wait_fs("F");

        // Watchdog: third frame without a write is still live, fourth trips.
        expect_frame(pw(40), pw(0), pw(10), pw(50));
        wait_fs("G");
        check("pretrip_timeout", timeout, 0);
        expect_frame(pw(0), pw(0), pw(0), pw(0));
        wait_fs("H");
        check("trip_timeout", timeout, 1);
        expect_frame(pw(0), pw(0), pw(0), pw(0));
        wait_fs("I");
        skip(119);
        write(15, 15, 15, 15);

        // One-cycle reset mid-pulse in J; K starts fresh from a cleared shadow.
        wait_fs("J");
        skip(19);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        expect_frame(pw(0), pw(0), pw(0), pw(0));
        @(negedge clk);
        check("rst2_pwm", pwm, 0);
        check("rst2_fs", frame_start, 0);
        check("rst2_timeout", timeout, 1);
        wait_fs("K");
        check("rst2_first_pwm", pwm, 4'hF);
        wait_fs("L");
        @(posedge clk);
        check("sb_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/esc_pwm_array.md
# esc_pwm_array

Multi-channel, frame-synchronous ESC pulse generator. Each channel outputs one active-high pulse per frame, with width MIN_PULSE + SCALE·speed clocks. The block adds three protections: per-channel speed clamping, an arm gate, and a write watchdog that idles all motors when the flight controller stops updating. It sits between the flight controller's motor-mix outputs and the ESC pins, and replaces the single-channel, write-triggered ESC interface.

## Interface
- NUM_CH, 4: number of ESC channels.
- SPEED_W, 11: width of each speed field.
- SCALE, 3: clocks of pulse width per speed LSB.
- MIN_PULSE, 6250: pulse width at speed 0, in clocks.
- MAX_SPEED, 2047: clamp ceiling applied to each speed field.
- PERIOD, 125000: frame length in clocks (400 Hz at 50 MHz). Must satisfy MIN_PULSE + SCALE·MAX_SPEED < PERIOD.
- TIMEOUT_FRAMES, 10: frame starts without a write before the watchdog trips.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- wrt  input  1  one-cycle strobe that captures all speed fields.
- speed  input  NUM_CH·SPEED_W  packed speeds; channel i occupies [i·SPEED_W +: SPEED_W].
- arm  input  1  when low, every channel's effective speed is 0.
- PWM  output  NUM_CH  ESC pulse per channel, registered.
- frame_start  output  1  one-cycle pulse in the first cycle of each frame, registered.
- timeout  output  1  watchdog tripped, registered level.

## Operation
- Reset (rst_n low at an edge) sets:
  - PWM = 0, frame_start = 0, timeout = 1 (the block is unfed until the first write).
  - Shadow speeds = 0, pulse counters = 0, watchdog count = 0.
  - Frame counter = PERIOD−1.
- Frame counter counts PERIOD−1 down to 0 and reloads to PERIOD−1. The edge at which it holds 0 is the frame-start edge.
- Shadow register: on a wrt edge, shadow[i] ← min(speed_i, MAX_SPEED). Shadow values are never applied mid-frame.
- Effective speed for channel i at a frame-start edge:
  - Base value: eff_i = wrt ? min(speed_i, MAX_SPEED) : shadow[i]. A write on the frame-start edge therefore bypasses the shadow.
  - eff_i is forced to 0 if arm = 0 or the watchdog trips on that edge.
- At the frame-start edge:
  - Pulse counter i ← MIN_PULSE + SCALE·eff_i.
  - PWM[i] ← 1 and frame_start ← 1.
- Pulse counting:
  - Each later edge decrements every nonzero pulse counter.
  - PWM[i] falls on the edge where counter i goes 1→0.
  - PWM[i] is high for exactly MIN_PULSE + SCALE·eff_i cycles.
- Arithmetic:
  - Pulse counters and the frame counter are clog2(PERIOD) bits wide.
  - The multiply and add are unsigned and cannot overflow, by the parameter constraint.
- Watchdog:
  - Any wrt edge clears the count to 0 and sets timeout ← 0.
  - Each frame-start edge without wrt increments the count, saturating at TIMEOUT_FRAMES.
  - When the count reaches TIMEOUT_FRAMES, timeout ← 1 on that edge, and that frame and all later frames use eff = 0.
  - The tripped state holds until the next wrt. Shadow values are kept, so the next frame after that write uses the new values.
- arm only gates the effective speed; it does not affect the shadow or the watchdog.

## Timing
- Latency from a write to the ESC is at most PERIOD cycles; pulses always start at frame start.
- First frame start is the first edge with rst_n high. PWM rises together with frame_start on that edge.
- A wrt in the middle of a frame:
  - Captures into the shadow.
  - Does not change pulses already in flight.
  - Appears from the next frame start.
- A wrt and a frame start on the same edge: the new value is used for this frame, and the watchdog clears rather than increments.
- Reset mid-frame: PWM, frame_start and timeout take their reset values on that edge; pulses are truncated with no glitch.
- Channels are mutually independent, and all rise on the same edge.

## Test plan
- Reset, then wrt with speeds {0, 2047, 1000, 3000} on ch0..3, arm = 1 → at the next frame start PWM widths are 6250, 12391, 9250 and 12391 clocks. Ch3 is clamped to 2047; the field is 11 bits wide, so drive 2047 with MAX_SPEED = 1500 to check the clamp gives 10750.
- After reset, with no wrt: timeout = 1, and the first frame starts on the first edge after reset is released, with all channels 6250 cycles wide; frame_start recurs every 125000 cycles.
- wrt of 500 at frame cycle 3000, during a 1000-valued pulse → the current pulse stays at 9250; the next frame is 7750.
- Watchdog: wrt of 1000, then none → frames 1–9 are 9250 clocks wide. At the 10th frame start timeout rises and the width becomes 6250. A later wrt drops timeout on its edge.
- arm = 0 during frames with speed 1000 → width 6250 and timeout unaffected; arm = 1 restores 9250 at the next frame.
- Assert rst_n low for 1 cycle at frame cycle 4000 → PWM = 0 on the next edge, then a fresh frame starts the cycle after rst_n returns high, at width 6250 because the shadow was cleared.
